// File: rtl/mem_modport_pkg.sv
// Shared types and constants for the req/gnt/rvalid memory responder.
// The LFSR constants are only consumed when MEM_MODPORT_STALL_EN is defined.
`timescale 1ns/1ps
package mem_modport_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int BE_W   = DATA_W / 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [BE_W-1:0]   be_t;

    typedef struct packed {
        logic  valid;
        data_t rdata;
    } resp_t;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] state);
        return {state[6:0], ^(state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/mem_modport_resp_pipe.sv
// Fixed-depth response delay line; every stage is cleared by srst so that
// responses in flight at reset are dropped.
`timescale 1ns/1ps
module mem_modport_resp_pipe
    import mem_modport_pkg::*;
#(
    parameter int  LATENCY = 1,
    parameter type RESP_T  = resp_t
) (
    input  logic  clk,
    input  logic  srst,
    input  RESP_T i_resp,
    output RESP_T o_resp
);

    RESP_T [LATENCY-1:0] r_stage;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_stage <= '0;
        end else begin
            r_stage[0] <= i_resp;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_resp = r_stage[LATENCY-1];

endmodule

// File: rtl/mem_modport_responder.sv
// Memory-side endpoint of the req/gnt/rvalid bus: byte-enabled word array with
// fixed-latency in-order responses. Optional random stall: MEM_MODPORT_STALL_EN.
`timescale 1ns/1ps
module mem_modport_responder
    import mem_modport_pkg::*;
#(
    parameter int ADDRESS_SIZE = ADDR_W,
    parameter int DATA_WIDTH   = DATA_W,
    parameter int DEPTH        = 1024,
    parameter int LATENCY      = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDRESS_SIZE-1:0] address,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    input  logic                    data_req,
    input  logic                    data_we,
    input  logic [DATA_WIDTH/8-1:0] data_be,
    output logic                    data_gnt,
    output logic                    data_rvalid,
    output logic [DATA_WIDTH-1:0]   data_rdata
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int OFS      = $clog2(BE_WIDTH);
    localparam int IDX_W    = $clog2(DEPTH);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rdata;
    } resp_w_t;

    logic                  w_gnt;
    logic                  w_stall;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_unused_addr;
    resp_w_t               w_resp_in;
    resp_w_t               w_resp_out;

    // Sub-word offset and bits above the array size do not select a word
    assign w_idx         = address[OFS +: IDX_W];
    assign w_unused_addr = ^{address[ADDRESS_SIZE-1:OFS+IDX_W], address[OFS-1:0]};

`ifdef MEM_MODPORT_STALL_EN
    logic [7:0] r_lfsr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign w_stall = r_lfsr[0];
`else
    assign w_stall = 1'b0;
`endif

    assign w_gnt    = data_req & ~rst_i & ~w_stall;
    assign data_gnt = w_gnt;

    // One narrow array per byte lane keeps each lane a plain write-enabled RAM
    genvar gi;
    generate
        for (gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
            logic [7:0] r_lane [DEPTH];

            always_ff @(posedge clk_i) begin
                if (w_gnt && data_we && data_be[gi]) begin
                    r_lane[w_idx] <= data_wdata[8*gi +: 8];
                end
            end

            assign w_rd_word[8*gi +: 8] = r_lane[w_idx];
        end
    endgenerate

    always_comb begin
        w_resp_in       = '0;
        w_resp_in.valid = w_gnt;
        if (w_gnt && !data_we) begin
            w_resp_in.rdata = w_rd_word;
        end
    end

    mem_modport_resp_pipe #(
        .LATENCY (LATENCY),
        .RESP_T  (resp_w_t)
    ) u_resp_pipe (
        .clk    (clk_i),
        .srst   (rst_i),
        .i_resp (w_resp_in),
        .o_resp (w_resp_out)
    );

    // Gate with reset so a response due in the reset cycle itself is dropped
    assign data_rvalid = w_resp_out.valid & ~rst_i;
    assign data_rdata  = (w_resp_out.valid && !rst_i) ? w_resp_out.rdata : '0;

endmodule

// File: tb/tb_mem_modport_responder.sv
// Randomized bench for mem_modport_responder against a scoreboard model of
// word memory, fixed-latency in-order responses and (optionally) LFSR stalls.
`timescale 1ns/1ps
module tb_mem_modport_responder;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [BW-1:0] data_be = '0;
    logic          data_gnt;
    logic          data_rvalid;
    logic [DW-1:0] data_rdata;

    mem_modport_responder #(
        .ADDRESS_SIZE (AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .LATENCY      (LAT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .address     (address),
        .data_wdata  (data_wdata),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_be     (data_be),
        .data_gnt    (data_gnt),
        .data_rvalid (data_rvalid),
        .data_rdata  (data_rdata)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [BW-1:0] be;
    } req_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    int n_tests = 0;
    int n_fail  = 0;

    req_t          pend[$];
    rsp_t          exp_q[$];
    logic [DW-1:0] mem_m [DEPTH];
    logic [7:0]    lfsr_m = 8'hA5;
    int            cyc = 0;

    logic          og[$], ov[$], eg_l[$], ev_l[$];
    logic [DW-1:0] od[$], ed_l[$];

    task automatic push_req(input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [BW-1:0] be);
        req_t r;
        r.we = we; r.addr = a; r.wdata = wd; r.be = be;
        pend.push_back(r);
    endtask

    // Model of one cycle from the bus-level rules; called with inputs stable
    task automatic model_tick(output logic eg, output logic ev, output logic [DW-1:0] ed);
        int   idx;
        rsp_t r;
        if (rst_i) exp_q.delete();
`ifdef MEM_MODPORT_STALL_EN
        eg = data_req && !rst_i && !lfsr_m[0];
`else
        eg = data_req && !rst_i;
`endif
        ev = 1'b0;
        ed = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            ev = 1'b1;
            ed = exp_q[0].data;
            exp_q.delete(0);
        end
        if (eg) begin
            idx = int'((address / BW) % DEPTH);
            r.due = cyc + LAT;
            r.data = '0;
            if (data_we) begin
                for (int b = 0; b < BW; b++)
                    if (data_be[b]) mem_m[idx][8*b +: 8] = data_wdata[8*b +: 8];
            end else begin
                r.data = mem_m[idx];
            end
            exp_q.push_back(r);
        end
        lfsr_m = rst_i ? 8'hA5 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        cyc++;
    endtask

    // Drives pend (holding each request until granted) and logs DUT vs model
    task automatic run_traffic(input int max_cyc, input int min_cyc, input int rst_cycle);
        logic          eg, ev;
        logic [DW-1:0] ed;
        og.delete(); ov.delete(); od.delete();
        eg_l.delete(); ev_l.delete(); ed_l.delete();
        for (int c = 0; c < max_cyc; c++) begin
            if (pend.size() > 0) begin
                data_req = 1'b1; data_we = pend[0].we; address = pend[0].addr;
                data_wdata = pend[0].wdata; data_be = pend[0].be;
            end else begin
                data_req = 1'b0; data_we = 1'($urandom_range(0, 1));
                address = {$urandom, $urandom}; data_wdata = {$urandom, $urandom}; data_be = '1;
            end
            rst_i = (c == rst_cycle);
            @(negedge clk_i);
            model_tick(eg, ev, ed);
            og.push_back(data_gnt); ov.push_back(data_rvalid); od.push_back(data_rdata);
            eg_l.push_back(eg); ev_l.push_back(ev); ed_l.push_back(ed);
            if (c == rst_cycle) pend.delete();
            else if (eg && pend.size() > 0) pend.delete(0);
            @(posedge clk_i); #1;
            if (pend.size() == 0 && exp_q.size() == 0 && c >= min_cyc) break;
        end
        rst_i = 1'b0;
        data_req = 1'b0;
        n_tests++;
        if (pend.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d outstanding=%0d, required 0 and 0",
                     pend.size(), exp_q.size());
            pend.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic          eg, ev;
        logic [DW-1:0] ed;
        rst_i = 1'b1;
        data_req = 1'b1;
        address = 64'h10;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            model_tick(eg, ev, ed);
            n_tests++;
            if (data_gnt !== 1'b0 || data_rvalid !== 1'b0 || data_rdata !== '0) begin
                n_fail++;
                $display("FAIL reset c%0d: gnt=%b rvalid=%b rdata=%h, required 0/0/0",
                         c, data_gnt, data_rvalid, data_rdata);
            end
            @(posedge clk_i); #1;
        end
        rst_i = 1'b0;
        data_req = 1'b0;
    endtask

    task automatic test_write_read();
        int gc[$], vc[$];
        push_req(1'b1, 64'h10, 64'h1122334455667788, 8'hFF);
        push_req(1'b0, 64'h10, 64'h0, 8'h00);
        run_traffic(100, 0, -1);
        for (int i = 0; i < og.size(); i++) begin
            n_tests++;
            if (og[i] !== eg_l[i] || ov[i] !== ev_l[i] || od[i] !== ed_l[i]) begin
                n_fail++;
                $display("FAIL wr_rd c%0d: gnt=%b rv=%b rd=%h, required gnt=%b rv=%b rd=%h",
                         i, og[i], ov[i], od[i], eg_l[i], ev_l[i], ed_l[i]);
            end
            if (og[i] === 1'b1) gc.push_back(i);
            if (ov[i] === 1'b1) vc.push_back(i);
        end
        n_tests++;
        if (gc.size() != 2 || vc.size() != 2) begin
            n_fail++;
            $display("FAIL wr_rd_count: grants=%0d rvalids=%0d, required 2 and 2", gc.size(), vc.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (vc[k] - gc[k] != LAT) begin
                    n_fail++;
                    $display("FAIL wr_rd_latency #%0d: %0d cycles, required %0d", k, vc[k] - gc[k], LAT);
                end
            end
            n_tests++;
            if (od[vc[0]] !== 64'h0 || od[vc[1]] !== 64'h1122334455667788) begin
                n_fail++;
                $display("FAIL wr_rd_data: write_rsp=%h read=%h, required 0 and 1122334455667788",
                         od[vc[0]], od[vc[1]]);
            end
        end
    endtask

    task automatic test_byte_enable();
        logic [DW-1:0] last_rd;
        push_req(1'b1, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        push_req(1'b0, 64'h10, 64'h0, 8'h00);
        run_traffic(100, 0, -1);
        last_rd = 'x;
        for (int i = 0; i < og.size(); i++) begin
            n_tests++;
            if (og[i] !== eg_l[i] || ov[i] !== ev_l[i] || od[i] !== ed_l[i]) begin
                n_fail++;
                $display("FAIL byte_en c%0d: gnt=%b rv=%b rd=%h, required gnt=%b rv=%b rd=%h",
                         i, og[i], ov[i], od[i], eg_l[i], ev_l[i], ed_l[i]);
            end
            if (ov[i] === 1'b1) last_rd = od[i];
        end
        n_tests++;
        if (last_rd !== 64'h11223344FFFFFFFF) begin
            n_fail++;
            $display("FAIL byte_en_data: read=%h, required 11223344ffffffff", last_rd);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] rd[$];
        push_req(1'b1, 64'h0, 64'hAB, 8'hFF);
        push_req(1'b0, 64'h2000, 64'h0, 8'h00);
        push_req(1'b0, 64'h7, 64'h0, 8'h00);
        run_traffic(100, 0, -1);
        for (int i = 0; i < og.size(); i++) begin
            n_tests++;
            if (og[i] !== eg_l[i] || ov[i] !== ev_l[i] || od[i] !== ed_l[i]) begin
                n_fail++;
                $display("FAIL wrap c%0d: gnt=%b rv=%b rd=%h, required gnt=%b rv=%b rd=%h",
                         i, og[i], ov[i], od[i], eg_l[i], ev_l[i], ed_l[i]);
            end
            if (ov[i] === 1'b1) rd.push_back(od[i]);
        end
        n_tests++;
        if (rd.size() != 3 || rd[1] !== 64'hAB || rd[2] !== 64'hAB) begin
            n_fail++;
            $display("FAIL wrap_data: responses=%0d, required 3 with reads of 0x2000 and 0x7 = ab", rd.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wv [4];
        int vc[$];
        int exp_cnt;
        int got_cnt;
        for (int w = 0; w < 4; w++) begin
            wv[w] = {$urandom, $urandom};
            push_req(1'b1, 64'(w * BW), wv[w], 8'hFF);
        end
        for (int w = 0; w < 4; w++) push_req(1'b0, 64'(w * BW), 64'h0, 8'h00);
        run_traffic(200, 0, -1);
        for (int i = 0; i < og.size(); i++) begin
            n_tests++;
            if (og[i] !== eg_l[i] || ov[i] !== ev_l[i] || od[i] !== ed_l[i]) begin
                n_fail++;
                $display("FAIL b2b c%0d: gnt=%b rv=%b rd=%h, required gnt=%b rv=%b rd=%h",
                         i, og[i], ov[i], od[i], eg_l[i], ev_l[i], ed_l[i]);
            end
            if (ov[i] === 1'b1) vc.push_back(i);
        end
`ifndef MEM_MODPORT_STALL_EN
        n_tests++;
        if (vc.size() != 8 || vc[7] - vc[0] != 7 || od[vc[4]] !== wv[0] || od[vc[5]] !== wv[1]
            || od[vc[6]] !== wv[2] || od[vc[7]] !== wv[3]) begin
            n_fail++;
            $display("FAIL b2b_order: %0d responses, required 8 consecutive with read data in word order",
                     vc.size());
        end
`endif
        // Reset in cycle 2 of a 4-read burst kills everything still in flight
        for (int w = 0; w < 4; w++) push_req(1'b0, 64'(w * BW), 64'h0, 8'h00);
        run_traffic(50, 8, 2);
        got_cnt = 0;
        for (int i = 0; i < og.size(); i++) begin
            n_tests++;
            if (og[i] !== eg_l[i] || ov[i] !== ev_l[i] || od[i] !== ed_l[i]) begin
                n_fail++;
                $display("FAIL b2b_rst c%0d: gnt=%b rv=%b rd=%h, required gnt=%b rv=%b rd=%h",
                         i, og[i], ov[i], od[i], eg_l[i], ev_l[i], ed_l[i]);
            end
            if (ov[i] === 1'b1) got_cnt++;
        end
`ifndef MEM_MODPORT_STALL_EN
        exp_cnt = 0;
        for (int g = 0; g < 2; g++) if (g + LAT < 2) exp_cnt++;
        n_tests++;
        if (got_cnt != exp_cnt) begin
            n_fail++;
            $display("FAIL b2b_rst_count: %0d rvalids, required %0d", got_cnt, exp_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        int            w;
        for (int k = 0; k < 16; k++) push_req(1'b1, 64'(k * BW), {$urandom, $urandom}, 8'hFF);
        for (int k = 0; k < 48; k++) begin
            w = $urandom_range(0, 15);
            a = {$urandom, $urandom};
            a = (a & ~(64'(DEPTH - 1) << 3)) | (64'(w) << 3);
            push_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom));
        end
        run_traffic(1000, 0, -1);
        for (int i = 0; i < og.size(); i++) begin
            n_tests++;
            if (og[i] !== eg_l[i] || ov[i] !== ev_l[i] || od[i] !== ed_l[i]) begin
                n_fail++;
                $display("FAIL random c%0d: gnt=%b rv=%b rd=%h, required gnt=%b rv=%b rd=%h",
                         i, og[i], ov[i], od[i], eg_l[i], ev_l[i], ed_l[i]);
            end
        end
    endtask

`ifdef MEM_MODPORT_STALL_EN
    task automatic test_stall();
        logic [7:0] l;
        int         ng, nv;
        for (int k = 0; k < 24; k++) push_req(1'b0, 64'h0, 64'h0, 8'h00);
        run_traffic(300, 0, 0);
        l = 8'hA5;
        ng = 0;
        nv = 0;
        for (int c = 1; c <= 16 && c < og.size(); c++) begin
            n_tests++;
            if (og[c] !== !l[0]) begin
                n_fail++;
                $display("FAIL stall_gnt c%0d: gnt=%b, required %b (lfsr %h)", c, og[c], !l[0], l);
            end
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        for (int i = 0; i < og.size(); i++) begin
            if (og[i] === 1'b1) ng++;
            if (ov[i] === 1'b1) nv++;
        end
        n_tests++;
        if (ng != 24 || nv != ng) begin
            n_fail++;
            $display("FAIL stall_count: grants=%0d rvalids=%0d, required 24 and 24", ng, nv);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_wrap();
        test_back_to_back();
        test_random();
`ifdef MEM_MODPORT_STALL_EN
        test_stall();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
